// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: state encoding,
// default operand width and the iteration-counter width helper.
package seq_restoring_divider_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter must hold 0..width-1; never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Request/result bundle between a divider client (master) and the divider (slave).
interface seq_restoring_divider_if #(
  parameter int WIDTH = seq_restoring_divider_pkg::DEF_WIDTH
);
  import seq_restoring_divider_pkg::*;

  // start is a request sampled only while the divider is idle; while busy it is
  // ignored and never queued. done pulses for one cycle with results valid, and
  // quotient/remainder/div_by_zero hold until the next accepted start.
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  state_e           dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, dbg_state
  );

endinterface

// File: rtl/seq_restoring_divider_sub.sv
// Ripple-borrow subtractor: a - b as a + ~b + 1 through a chain of full adders.
module ripple_borrow_subtractor #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] carry;

  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic b_n;
    assign b_n         = ~b_i[i];
    assign diff_o[i]   = a_i[i] ^ b_n ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_n) | (a_i[i] & carry[i]) | (b_n & carry[i]);
  end

  // No carry out of the top means the subtraction went negative.
  assign borrow_o = ~carry[N];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, results
// registered and held; divide-by-zero short-circuits straight to DONE.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] d_q;
  logic [CW-1:0]    cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             borrow;
  logic [WIDTH:0]   r_d;
  logic [WIDTH-1:0] q_d;
  logic             last_iter;
  logic             unused_r_msb;

  // The partial remainder stays below the divisor, so its top bit is always
  // clear before the shift and only the low WIDTH bits feed the next step.
  assign r_shift      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign unused_r_msb = r_q[WIDTH];

  ripple_borrow_subtractor #(
    .N (WIDTH + 1)
  ) u_sub (
    .a_i      (r_shift),
    .b_i      ({1'b0, d_q}),
    .diff_o   (trial),
    .borrow_o (borrow)
  );

  assign r_d       = borrow ? r_shift : trial;
  assign q_d       = {q_q[WIDTH-2:0], ~borrow};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            q_q    <= bus.dividend;
            d_q    <= bus.divisor;
            r_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (bus.divisor == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              quot_q  <= '1;
              rem_q   <= bus.dividend;
            end else begin
              state_q <= ST_CALC;
              dbz_q   <= 1'b0;
            end
          end
        end

        ST_CALC: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          // Results are taken from the final iteration's next values so they
          // are already registered when done is raised.
          if (last_iter) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            quot_q  <= q_d;
            rem_q   <= r_d[WIDTH-1:0];
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed cases plus random divisions checked
// against an arithmetic reference through an expected-result queue.
module tb_seq_restoring_divider;
  import seq_restoring_divider_pkg::*;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  int checks = 0;
  int errors = 0;

  logic [2*W:0] exp_q[$];
  logic [W-1:0] hold_q;
  logic [W-1:0] hold_r;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: {div_by_zero, quotient, remainder} from plain arithmetic.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    if (b == '0) return {1'b1, {W{1'b1}}, a};
    return {1'b0, W'(a / b), W'(a % b)};
  endfunction

  // ---------------- drivers ----------------
  // Called on a negedge; start is sampled on the following posedge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    exp_q.push_back(ref_div(a, b));
    if (!hold) begin
      @(posedge clk);
      #1;
      bus.start    = 1'b0;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
    end
  endtask

  // Counts negedge samples after acceptance until done; inj>0 pulses a stray
  // start (8/2) in that cycle.
  task automatic wait_done(input int max, input int inj, output int cyc, output int busy_n);
    bit seen;
    logic [2*W:0] e;
    seen = 1'b0;
    cyc = 0;
    busy_n = 0;
    while (cyc < max && !seen) begin
      @(negedge clk);
      cyc++;
      if (cyc == inj) begin
        bus.start = 1'b1; bus.dividend = 8'd8; bus.divisor = 8'd2;
      end else if (inj > 0 && cyc == inj + 1) begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        check_val("hold_quotient", 32'(bus.quotient), 32'(hold_q));
        check_val("hold_remainder", 32'(bus.remainder), 32'(hold_r));
      end
    end
    if (!seen) begin
      check_val("done_timeout", 32'd0, 32'd1);
    end else if (exp_q.size() == 0) begin
      check_val("unexpected_done", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_val("quotient", 32'(bus.quotient), 32'(e[2*W-1:W]));
      check_val("remainder", 32'(bus.remainder), 32'(e[W-1:0]));
      check_val("div_by_zero", 32'(bus.div_by_zero), 32'(e[2*W]));
      hold_q = e[2*W-1:W];
      hold_r = e[W-1:0];
    end
  endtask

  task automatic post_step();
    @(negedge clk);
    check_val("done_one_cycle", 32'(bus.done), 32'd0);
    check_val("busy_after_done", 32'(bus.busy), 32'd0);
    check_val("state_idle", 32'(bus.dbg_state), 32'(ST_IDLE));
  endtask

  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc, bn, lat;
    lat = (b == '0) ? 1 : W + 1;
    issue(a, b, 1'b0);
    wait_done(40, 0, cyc, bn);
    check_val("latency", 32'(cyc), 32'(lat));
    check_val("busy_cycles", 32'(bn), 32'(lat));
    post_step();
  endtask

  task automatic watch_no_done(input int n);
    int pulses;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.done) pulses++;
    end
    check_val("no_extra_done", 32'(pulses), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc, bn;
    logic [W-1:0] a, b;

    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    hold_q = '0;
    hold_r = '0;
    rst_n  = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_busy", 32'(bus.busy), 32'd0);
    check_val("rst_done", 32'(bus.done), 32'd0);
    check_val("rst_quotient", 32'(bus.quotient), 32'd0);
    check_val("rst_remainder", 32'(bus.remainder), 32'd0);
    check_val("rst_dbz", 32'(bus.div_by_zero), 32'd0);
    check_val("rst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic division
    run_one(8'd229, 8'd21);

    // Back-to-back with start held high through DONE
    issue(8'd213, 8'd2, 1'b1);
    wait_done(40, 0, cyc, bn);
    check_val("b2b_first_latency", 32'(cyc), 32'd9);
    issue(8'd55, 8'd128, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(40, 0, cyc, bn);
    check_val("b2b_gap", 32'(cyc + 1), 32'd10);
    post_step();

    // Boundary operands
    run_one(8'd255, 8'd1);
    run_one(8'd255, 8'd255);
    run_one(8'd192, 8'd63);
    run_one(8'd0, 8'd17);

    // Divide by zero, then a normal division clears the flag
    run_one(8'd200, 8'd0);
    run_one(8'd100, 8'd7);

    // Stray start during CALC is ignored
    issue(8'd229, 8'd21, 1'b0);
    wait_done(40, 3, cyc, bn);
    check_val("ignored_start_latency", 32'(cyc), 32'd9);
    watch_no_done(15);
    check_val("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset mid-division
    issue(8'd229, 8'd21, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("arst_busy", 32'(bus.busy), 32'd0);
    check_val("arst_done", 32'(bus.done), 32'd0);
    check_val("arst_quotient", 32'(bus.quotient), 32'd0);
    check_val("arst_remainder", 32'(bus.remainder), 32'd0);
    check_val("arst_dbz", 32'(bus.div_by_zero), 32'd0);
    check_val("arst_state", 32'(bus.dbg_state), 32'(ST_IDLE));
    exp_q.delete();
    hold_q = '0;
    hold_r = '0;
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done(12);
    run_one(8'd229, 8'd21);

    // Random divisions, roughly one in eight by zero
    for (int i = 0; i < 40; i++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom_range(1, 255));
      run_one(a, b);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Sequential unsigned restoring divider: the inverse operation of the unsigned array multiplier.
- Accepts a WIDTH-bit dividend and divisor on a start pulse.
- Produces the quotient and remainder after WIDTH iteration cycles, one quotient bit per cycle.
- Uses a ripple-borrow trial subtractor built in the same style as the team's carry-ripple adders.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (supported range 2..16).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend, sampled with start.
- divisor  input  WIDTH  unsigned divisor, sampled with start.
- busy  output  1  high while a division is in progress (CALC and DONE).
- done  output  1  one-cycle pulse; results valid on this cycle.
- quotient  output  WIDTH  unsigned quotient; held until the next accepted start.
- remainder  output  WIDTH  unsigned remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when divisor==0; held until the next accepted start.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE.
  - busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0.
  - Internal count and registers cleared.
  - Reset mid-operation aborts the division with no done pulse.
- States: IDLE, CALC, DONE.
- IDLE, start=1 (cycle T):
  - Latch dividend into Q register and divisor into D register.
  - Clear the R register (WIDTH+1 bits); count=0; div_by_zero=0.
  - If divisor==0: next state DONE.
  - Otherwise: next state CALC.
- CALC, one iteration per cycle:
  - {R,Q} shifted left 1.
  - trial = R_shifted - {1'b0,D}, WIDTH+1 bits, computed by the sub-module.
  - If no borrow: R=trial and Q[0]=1. Otherwise R is kept (restored) and Q[0]=0.
  - count increments; after the WIDTH-th iteration (count==WIDTH-1) next state is DONE.
- DONE, one cycle:
  - done=1.
  - quotient=Q, remainder=R[WIDTH-1:0].
  - Then IDLE.
- Divide by zero:
  - Skips CALC; DONE at T+1.
  - quotient=all ones, remainder=dividend, div_by_zero=1.
- Latency, start accepted at T:
  - Normal: done at T+WIDTH+1 (T+9 for WIDTH=8).
  - Divide by zero: done at T+1.
- busy:
  - High from T+1 through the done cycle inclusive.
  - Low in IDLE.
- start while busy (CALC or DONE): ignored; no queueing.
  - start held high through DONE is accepted on the first IDLE cycle after it.
  - Back-to-back throughput is therefore one division per WIDTH+2 cycles.
- Operand inputs may change freely after T; only the latched copies are used.
- Result outputs change only on the done cycle and otherwise hold.
- Arithmetic:
  - All unsigned.
  - R is WIDTH+1 bits so the shifted partial remainder never overflows.
  - Invariant: quotient*divisor + remainder == dividend, and remainder < divisor when divisor != 0.

Decomposition:
- Shared package/include div_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_DONE=2'd2.
  - Default WIDTH constant.
  - Count width as clog2(WIDTH).
- Sub-module ripple_borrow_subtractor:
  - Parameterised width (instantiated at WIDTH+1).
  - Computes a + ~b + 1 via a chain of full adders.
  - Outputs diff and borrow (borrow = ~carry_out).

Test Plan:
- 229/21, start for 1 cycle -> done exactly 9 cycles later; quotient=10, remainder=19, div_by_zero=0; busy high 9 cycles.
- 213/2, then 55/128 back-to-back (start held high) -> 106 r1; then 0 r55; second done 10 cycles after the first.
- 255/1 and 255/255 -> 255 r0 and 1 r0; 192/63 -> 3 r3.
- 200/0 -> done at T+1, quotient=255, remainder=200, div_by_zero=1; next valid division clears div_by_zero.
- start pulsed at T+3 during a 229/21 run with operands 8/2 -> ignored; result still 10 r19; only one done pulse.
- rst_n low at T+4 of a division -> all outputs 0 immediately (async); no done pulse; a new start after release gives the correct result.
